// File: rtl/multi_clock_divider.sv
// multi_clock_divider
//   NUM_CH independent clock dividers running from one input clock. Each channel
//   toggles its output after (divisor + 1) input cycles. The channel also gives a
//   one-cycle tick on every rising output edge. A new divisor is written into a
//   pending register and only takes effect at the next toggle, so a half-period
//   already in progress is never cut short. A global sync restarts all enabled
//   channels in phase.
//
//   Optional feature macro: CLKDIV_DUTY_EN
//     When defined, each channel has separate high-half and low-half divisors.
//     wr_sel picks the target of a write: 0 = high, 1 = low. A pending high divisor
//     is applied on the 0->1 toggle and a pending low divisor on the 1->0 toggle.
//     When undefined, wr_sel is ignored and one divisor sets both halves.
module multi_clock_divider #(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(32'd25000000)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic              wr_sel,
    input  logic [WIDTH-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    // A write aimed past the last channel is dropped here.
    logic wr_ok_s;
    assign wr_ok_s = wr_en && ({1'b0, wr_ch} < 5'(NUM_CH));

`ifndef CLKDIV_DUTY_EN
    logic unused_wr_sel_s;
    assign unused_wr_sel_s = wr_sel;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic [WIDTH-1:0] cur_div_s;
        logic             clk_q;
        logic             clk_d;
        logic             tick_q;
        logic             tick_d;
        logic             pend_q;
        logic             pend_d;
        logic             hit_s;
        logic             restart_s;
        logic             toggle_s;

        assign hit_s = wr_ok_s && (wr_ch == 4'(i));

        // Half-period counter, output level and rising-edge strobe.
        // The >= test makes the channel toggle at once if the divisor ever drops below the count.
        always_comb begin
            cnt_d     = cnt_q;
            clk_d     = clk_q;
            tick_d    = 1'b0;
            restart_s = 1'b0;
            toggle_s  = 1'b0;
            if (!en[i] || sync) begin
                cnt_d     = {WIDTH{1'b0}};
                clk_d     = 1'b0;
                restart_s = 1'b1;
            end else if (cnt_q >= cur_div_s) begin
                cnt_d    = {WIDTH{1'b0}};
                clk_d    = ~clk_q;
                tick_d   = ~clk_q;
                toggle_s = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end

`ifdef CLKDIV_DUTY_EN
        logic [WIDTH-1:0] act_hi_q;
        logic [WIDTH-1:0] act_hi_d;
        logic [WIDTH-1:0] act_lo_q;
        logic [WIDTH-1:0] act_lo_d;
        logic [WIDTH-1:0] nxt_hi_q;
        logic [WIDTH-1:0] nxt_hi_d;
        logic [WIDTH-1:0] nxt_lo_q;
        logic [WIDTH-1:0] nxt_lo_d;
        logic             pend_hi_q;
        logic             pend_hi_d;
        logic             pend_lo_q;
        logic             pend_lo_d;

        // The divisor in use depends on which half the output is in now.
        assign cur_div_s = clk_q ? act_hi_q : act_lo_q;

        // Divisor staging: each half applies its pending value on the toggle into that half.
        // A write in the same cycle is staged after the apply, so it waits for the next toggle.
        always_comb begin
            act_hi_d  = act_hi_q;
            act_lo_d  = act_lo_q;
            nxt_hi_d  = nxt_hi_q;
            nxt_lo_d  = nxt_lo_q;
            pend_hi_d = pend_hi_q;
            pend_lo_d = pend_lo_q;
            if (restart_s || (toggle_s && !clk_q)) begin
                act_hi_d  = nxt_hi_q;
                pend_hi_d = 1'b0;
            end else begin
                act_hi_d  = act_hi_q;
            end
            if (restart_s || (toggle_s && clk_q)) begin
                act_lo_d  = nxt_lo_q;
                pend_lo_d = 1'b0;
            end else begin
                act_lo_d  = act_lo_q;
            end
            if (hit_s && !wr_sel) begin
                nxt_hi_d  = wr_div;
                pend_hi_d = 1'b1;
            end else if (hit_s && wr_sel) begin
                nxt_lo_d  = wr_div;
                pend_lo_d = 1'b1;
            end else begin
                nxt_hi_d  = nxt_hi_q;
                nxt_lo_d  = nxt_lo_q;
            end
            pend_d = pend_hi_d | pend_lo_d;
        end

        // Divisor registers for the high and low halves.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                act_hi_q  <= DEFAULT_DIV;
                act_lo_q  <= DEFAULT_DIV;
                nxt_hi_q  <= DEFAULT_DIV;
                nxt_lo_q  <= DEFAULT_DIV;
                pend_hi_q <= 1'b0;
                pend_lo_q <= 1'b0;
            end else begin
                act_hi_q  <= act_hi_d;
                act_lo_q  <= act_lo_d;
                nxt_hi_q  <= nxt_hi_d;
                nxt_lo_q  <= nxt_lo_d;
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
            end
        end
`else
        logic [WIDTH-1:0] act_q;
        logic [WIDTH-1:0] act_d;
        logic [WIDTH-1:0] nxt_q;
        logic [WIDTH-1:0] nxt_d;

        assign cur_div_s = act_q;

        // Divisor staging: the pending value is applied on any toggle or restart.
        // A write in the same cycle is staged after the apply, so it waits for the next toggle.
        always_comb begin
            act_d  = act_q;
            nxt_d  = nxt_q;
            pend_d = pend_q;
            if (restart_s || toggle_s) begin
                act_d  = nxt_q;
                pend_d = 1'b0;
            end else begin
                act_d  = act_q;
            end
            if (hit_s) begin
                nxt_d  = wr_div;
                pend_d = 1'b1;
            end else begin
                nxt_d  = nxt_q;
            end
        end

        // Active and pending divisor registers.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                act_q <= DEFAULT_DIV;
                nxt_q <= DEFAULT_DIV;
            end else begin
                act_q <= act_d;
                nxt_q <= nxt_d;
            end
        end
`endif

        // Channel state and registered outputs.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                cnt_q  <= {WIDTH{1'b0}};
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                pend_q <= pend_d;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Testbench for multi_clock_divider: a directed vector table, randomized traffic checked
// against a remaining-cycles reference model, and hand sequences for the multi-cycle corners.
module tb_multi_clock_divider;

    localparam int          NCH = 4;
    localparam int unsigned DEF = 5;
`ifdef CLKDIV_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic [3:0]  en     = 4'b0000;
    logic        sync   = 1'b0;
    logic        wr_en  = 1'b0;
    logic [3:0]  wr_ch  = 4'd0;
    logic        wr_sel = 1'b0;
    logic [31:0] wr_div = 32'd0;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pend;

    int n_vec = 0;
    int n_err = 0;

    multi_clock_divider #(.NUM_CH(NCH), .WIDTH(32), .DEFAULT_DIV(32'd5)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_sel (wr_sel),
        .wr_div (wr_div),
        .clk_out(clk_out),
        .tick   (tick),
        .pend   (pend)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: each channel tracks the cycles left in its current half.
    int unsigned m_ahi [NCH];
    int unsigned m_alo [NCH];
    int unsigned m_phi [NCH];
    int unsigned m_plo [NCH];
    bit          m_fhi [NCH];
    bit          m_flo [NCH];
    bit          m_lvl [NCH];
    bit          m_tick[NCH];
    longint      m_rem [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ahi[c] = DEF; m_alo[c] = DEF; m_phi[c] = DEF; m_plo[c] = DEF;
            m_fhi[c] = 1'b0; m_flo[c] = 1'b0; m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
            m_rem[c] = longint'(DEF) + 1;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            if (!en[c] || sync) begin
                m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
                m_ahi[c] = m_phi[c]; m_alo[c] = m_plo[c];
                m_fhi[c] = 1'b0; m_flo[c] = 1'b0;
                m_rem[c] = longint'(m_alo[c]) + 1;
            end else begin
                m_tick[c] = 1'b0;
                m_rem[c]  = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    m_lvl[c]  = !m_lvl[c];
                    m_tick[c] = m_lvl[c];
                    if (!DUTY || m_lvl[c]) begin m_ahi[c] = m_phi[c]; m_fhi[c] = 1'b0; end
                    if (!DUTY || !m_lvl[c]) begin m_alo[c] = m_plo[c]; m_flo[c] = 1'b0; end
                    m_rem[c] = longint'(m_lvl[c] ? m_ahi[c] : m_alo[c]) + 1;
                end
            end
            if (wr_en && (int'(wr_ch) < NCH) && (int'(wr_ch) == c)) begin
                if (!DUTY || !wr_sel) begin m_phi[c] = wr_div; m_fhi[c] = 1'b1; end
                if (!DUTY || wr_sel)  begin m_plo[c] = wr_div; m_flo[c] = 1'b1; end
            end
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check(input string tag);
        logic [3:0] e_clk;
        logic [3:0] e_tick;
        logic [3:0] e_pend;
        for (int c = 0; c < NCH; c++) begin
            e_clk[c]  = m_lvl[c];
            e_tick[c] = m_tick[c];
            e_pend[c] = m_fhi[c] | m_flo[c];
        end
        chk({tag, " clk_out"}, clk_out, e_clk);
        chk({tag, " tick"}, tick, e_tick);
        chk({tag, " pend"}, pend, e_pend);
    endtask

    // Apply one cycle of inputs, advance the model on the edge, compare 1 time unit later.
    task automatic step(input logic [3:0] e, input logic s, input logic we, input logic ws,
                        input logic [3:0] wc, input logic [31:0] wd);
        en = e; sync = s; wr_en = we; wr_sel = ws; wr_ch = wc; wr_div = wd;
        @(posedge clk_in);
        model_step();
        #1;
        model_check("model");
    endtask

    task automatic idle();
        step(4'hF, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    typedef struct packed {
        logic [3:0]  en;
        logic        s;
        logic        we;
        logic [3:0]  wc;
        logic [31:0] wd;
        logic        e_clk;
        logic        e_tick;
        logic        e_pend;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] e, input logic s, input logic we,
                                input logic [3:0] wc, input logic [31:0] wd,
                                input logic ec, input logic et, input logic ep);
        vec_t v;
        v.en = e; v.s = s; v.we = we; v.wc = wc; v.wd = wd;
        v.e_clk = ec; v.e_tick = et; v.e_pend = ep;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   r0;
        int   r1;
        int   waited;
        int   len;
        logic lvl;

        // Directed table for channel 0 only (channels 1..3 held disabled).
        tbl.push_back(mk(4'b0001, 1'b0, 1'b1, 4'd0,  32'd3, 1'b0, 1'b0, 1'b1)); // 0 write D=3
        tbl.push_back(mk(4'b0001, 1'b1, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0)); // 1 sync applies
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b1, 1'b0)); // 5 rise
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0)); // 9 fall
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b1, 1'b0)); // 13 rise, period 8
        tbl.push_back(mk(4'b0001, 1'b0, 1'b1, 4'd0,  32'd1, 1'b1, 1'b0, 1'b1)); // 14 write D=1 mid-high
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0)); // 17 toggle, pend clears
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b1, 1'b0)); // 19 rise after 2
        tbl.push_back(mk(4'b0001, 1'b0, 1'b1, 4'd9,  32'd0, 1'b1, 1'b0, 1'b0)); // 20 wr_ch=9 ignored
        tbl.push_back(mk(4'b0001, 1'b0, 1'b1, 4'd12, 32'd0, 1'b0, 1'b0, 1'b0)); // 21 wr_ch=12 ignored
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b1, 1'b0)); // 23
        tbl.push_back(mk(4'b0001, 1'b0, 1'b1, 4'd0,  32'd2, 1'b1, 1'b0, 1'b1)); // 24 write D=2
        tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0)); // 25 disable applies
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0)); // 26 re-enable
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 1'b1, 1'b0)); // 28 rise after D+1

        // Reset state.
        #7;
        chk("reset clk_out", clk_out, 4'b0000);
        chk("reset tick", tick, 4'b0000);
        chk("reset pend", pend, 4'b0000);
        model_reset();
        @(negedge clk_in);
        rst = 1'b0;

`ifndef CLKDIV_DUTY_EN
        foreach (tbl[r]) begin
            step(tbl[r].en, tbl[r].s, tbl[r].we, 1'b0, tbl[r].wc, tbl[r].wd);
            chk($sformatf("tbl%0d clk_out", r), clk_out, {3'b000, tbl[r].e_clk});
            chk($sformatf("tbl%0d tick", r), tick, {3'b000, tbl[r].e_tick});
            chk($sformatf("tbl%0d pend", r), pend, {3'b000, tbl[r].e_pend});
        end
`endif

        // Randomized traffic against the model.
        en = 4'hF;
        for (int k = 0; k < 1500; k++) begin
            logic [3:0] e;
            e = ($urandom_range(0, 9) == 0) ? (4'($urandom) | 4'($urandom)) : en;
            step(e, ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
                 4'($urandom_range(0, 15)), 32'($urandom_range(0, 6)));
        end

`ifndef CLKDIV_DUTY_EN
        // Sync alignment: ch0 D=2 and ch1 D=5 restart together.
        step(4'hF, 1'b0, 1'b1, 1'b0, 4'd0, 32'd2);
        step(4'hF, 1'b0, 1'b1, 1'b0, 4'd1, 32'd5);
        step(4'hF, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        repeat (7) idle();
        step(4'hF, 1'b0, 1'b1, 1'b0, 4'd9, 32'd0);
        step(4'hF, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        chk("sync outputs low", {2'b00, clk_out[1:0]}, 4'b0000);
        r0 = -1; r1 = -1;
        for (int k = 1; k <= 10; k++) begin
            idle();
            if (r0 < 0 && clk_out[0]) r0 = k;
            if (r1 < 0 && clk_out[1]) r1 = k;
        end
        chk_int("sync rise ch0", r0, 3);
        chk_int("sync rise ch1", r1, 6);

        // Last write wins on ch2, and pend clears on the toggle itself.
        step(4'hF, 1'b0, 1'b1, 1'b0, 4'd2, 32'd4);
        step(4'hF, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        idle(); idle();
        step(4'hF, 1'b0, 1'b1, 1'b0, 4'd2, 32'd7);
        step(4'hF, 1'b0, 1'b1, 1'b0, 4'd2, 32'd2);
        chk("ch2 pend set", {3'b000, pend[2]}, 4'b0001);
        waited = -1; lvl = clk_out[2];
        for (int k = 1; k <= 20; k++) begin
            idle();
            if (!pend[2]) begin waited = k; break; end
        end
        chk_int("ch2 pend clear delay", waited, 1);
        chk_int("ch2 toggled with clear", int'(clk_out[2] != lvl), 1);
        lvl = clk_out[2]; len = -1;
        for (int k = 1; k <= 20; k++) begin
            idle();
            if (clk_out[2] != lvl) begin len = k; break; end
        end
        chk_int("ch2 half after last write", len, 3);

        // Disable ch3 while a write is pending, then re-enable.
        step(4'hF, 1'b0, 1'b1, 1'b0, 4'd3, 32'd3);
        chk("ch3 pend before disable", {3'b000, pend[3]}, 4'b0001);
        step(4'b0111, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        chk("ch3 disabled clk", {3'b000, clk_out[3]}, 4'b0000);
        chk("ch3 disabled pend", {3'b000, pend[3]}, 4'b0000);
        r0 = -1;
        for (int k = 1; k <= 20; k++) begin
            idle();
            if (clk_out[3]) begin r0 = k; break; end
        end
        chk_int("ch3 first rise after enable", r0, 4);
`else
        // Asymmetric duty on ch0: DH=1, DL=5.
        step(4'hF, 1'b0, 1'b1, 1'b0, 4'd0, 32'd1);
        step(4'hF, 1'b0, 1'b1, 1'b1, 4'd0, 32'd5);
        step(4'hF, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        for (int h = 0; h < 3; h++) begin
            lvl = clk_out[0]; len = -1;
            for (int k = 1; k <= 20; k++) begin
                idle();
                if (clk_out[0] != lvl) begin len = k; break; end
            end
            chk_int($sformatf("duty half %0d", h), len, lvl ? 2 : 6);
        end
`endif

        // Asynchronous reset in the middle of a half-period.
        for (int k = 0; k < 20; k++) begin
            if (clk_out != 4'b0000) break;
            idle();
        end
        chk("pre-reset activity", {3'b000, |clk_out}, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset clk_out", clk_out, 4'b0000);
        chk("async reset tick", tick, 4'b0000);
        chk("async reset pend", pend, 4'b0000);
        model_reset();
        #2;
        rst = 1'b0;
        repeat (14) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
